// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the next-PC mux select and the imem handshake.
// Trap redirects outrank branches; a redirect that misses an accept is pended until one occurs.
module fetch_pc_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        trap_i,
   input  logic [31:0] trap_vec_i,
   input  logic        imem_ready_i,
   output logic        imem_req_o,
   output logic [31:0] pc_o,
   output logic        mux_sel_o,
   output logic [31:0] mux_target_o,
   output logic        valid_o,
   output logic        flush_o
);

   typedef enum logic [1:0] {StIdle, StRun, StWait} state_e;

   state_e      state_q;
   logic        pend_valid_q;
   logic        pend_trap_q;
   logic [31:0] pend_target_q;

   logic        redir;
   logic        redir_trap;
   logic [31:0] redir_target;
   logic        req_raw;
   logic        accept;

   // New trap > pending trap > new branch > pending branch.
   always_comb begin
      redir        = 1'b1;
      redir_trap   = 1'b0;
      redir_target = pend_target_q;
      if (trap_i) begin
         redir_trap   = 1'b1;
         redir_target = trap_vec_i;
      end else if (pend_valid_q && pend_trap_q) begin
         redir_trap   = 1'b1;
      end else if (br_taken_i) begin
         redir_target = br_target_i;
      end else if (!pend_valid_q) begin
         redir        = 1'b0;
      end
   end

   always_comb begin
      req_raw = 1'b0;
      unique case (state_q)
         StIdle:  req_raw = 1'b0;
         StRun:   req_raw = !stall_i;
         StWait:  req_raw = 1'b1;
         default: req_raw = 1'b0;
      endcase
   end

   assign imem_req_o   = !rst && req_raw;
   assign accept       = imem_req_o && imem_ready_i;
   assign mux_sel_o    = redir && accept;
   assign mux_target_o = {redir_target[31:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         pc_o          <= RESET_PC;
         pend_valid_q  <= 1'b0;
         pend_trap_q   <= 1'b0;
         pend_target_q <= 32'h0;
         valid_o       <= 1'b0;
         flush_o       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle:  state_q <= StRun;
            StRun:   if (imem_req_o && !imem_ready_i) state_q <= StWait;
            StWait:  if (imem_ready_i) state_q <= StRun;
            default: state_q <= StIdle;
         endcase

         if (accept) begin
            pc_o         <= mux_sel_o ? mux_target_o : pc_o + 32'd4;
            valid_o      <= !redir;
            flush_o      <= redir;
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
         end else begin
            valid_o <= 1'b0;
            flush_o <= 1'b0;
            if (redir) begin
               pend_valid_q  <= 1'b1;
               pend_trap_q   <= redir_trap;
               pend_target_q <= redir_target;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: a behavioural model pushes expected per-cycle outputs,
// a monitor process pops and compares them against the DUT.
module tb_fetch_pc_ctrl;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        br_taken_i = 1'b0;
   logic [31:0] br_target_i = 32'h0;
   logic        trap_i = 1'b0;
   logic [31:0] trap_vec_i = 32'h0;
   logic        imem_ready_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] pc_o;
   logic        mux_sel_o;
   logic [31:0] mux_target_o;
   logic        valid_o;
   logic        flush_o;

   always #5 clk = ~clk;

   fetch_pc_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .br_taken_i   (br_taken_i),
      .br_target_i  (br_target_i),
      .trap_i       (trap_i),
      .trap_vec_i   (trap_vec_i),
      .imem_ready_i (imem_ready_i),
      .imem_req_o   (imem_req_o),
      .pc_o         (pc_o),
      .mux_sel_o    (mux_sel_o),
      .mux_target_o (mux_target_o),
      .valid_o      (valid_o),
      .flush_o      (flush_o)
   );

   typedef struct {
      bit          chk_regs;
      logic [31:0] pc;
      logic        valid;
      logic        flush;
      logic        req;
      logic        msel;
      logic [31:0] mtgt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state, in terms of observable behaviour.
   bit          m_known   = 1'b0;
   bit          m_started = 1'b0;   // an IDLE cycle has passed since reset
   bit          m_waiting = 1'b0;   // a request is outstanding and may not be withdrawn
   logic [31:0] m_pc      = 32'h0;
   bit          m_valid   = 1'b0;
   bit          m_flush   = 1'b0;
   int          m_pend    = 0;      // 0 none, 1 branch, 2 trap
   logic [31:0] m_pend_addr = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input bit r, input bit s, input bit b, input logic [31:0] bt,
                        input bit t, input logic [31:0] tv, input bit rd);
      exp_t        e;
      int          best;
      logic [31:0] addr;
      bit          req;
      bit          acc;
      @(negedge clk);
      rst = r; stall_i = s; br_taken_i = b; br_target_i = bt;
      trap_i = t; trap_vec_i = tv; imem_ready_i = rd;

      // Rank candidates; later (higher-ranked) ones override earlier ones.
      best = 0;
      addr = 32'h0;
      if (m_pend == 1) begin best = 1; addr = m_pend_addr; end
      if (b)           begin best = 2; addr = bt;          end
      if (m_pend == 2) begin best = 3; addr = m_pend_addr; end
      if (t)           begin best = 4; addr = tv;          end

      req = !r && m_started && (m_waiting || !s);
      acc = req && rd;

      e.chk_regs = m_known;
      e.pc       = m_pc;
      e.valid    = m_valid;
      e.flush    = m_flush;
      e.req      = req;
      e.msel     = acc && (best != 0);
      e.mtgt     = addr & ~32'h3;
      q.push_back(e);

      if (r) begin
         m_known = 1'b1; m_started = 1'b0; m_waiting = 1'b0;
         m_pc = RST_PC; m_valid = 1'b0; m_flush = 1'b0; m_pend = 0;
      end else begin
         if (acc) begin
            m_pc    = (best != 0) ? (addr & ~32'h3) : m_pc + 32'd4;
            m_valid = (best == 0);
            m_flush = (best != 0);
            m_pend  = 0;
         end else begin
            m_valid = 1'b0;
            m_flush = 1'b0;
            if (best != 0) begin
               m_pend      = (best >= 3) ? 2 : 1;
               m_pend_addr = addr;
            end
         end
         if (!m_started)     m_started = 1'b1;
         else if (m_waiting) m_waiting = !rd;
         else                m_waiting = req && !rd;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
   endtask

   // Monitor: samples 2 time units after each negedge, once inputs have settled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("imem_req", {31'h0, imem_req_o}, {31'h0, e.req});
            check("mux_sel", {31'h0, mux_sel_o}, {31'h0, e.msel});
            if (e.msel) check("mux_target", mux_target_o, e.mtgt);
            if (e.chk_regs) begin
               check("pc", pc_o, e.pc);
               check("valid", {31'h0, valid_o}, {31'h0, e.valid});
               check("flush", {31'h0, flush_o}, {31'h0, e.flush});
            end
         end
      end
   end

   initial begin
      logic [31:0] bt;
      logic [31:0] tv;
      // Reset, then sequential fetch through the 32-bit wrap.
      drive(1, 0, 0, 32'h0, 0, 32'h0, 1);
      drive(1, 0, 0, 32'h0, 0, 32'h0, 1);
      run(6);
      // Immediate branch.
      drive(0, 0, 1, 32'h100, 0, 32'h0, 1);
      run(2);
      // Redirect while waiting on memory.
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 0, 1, 32'h40, 0, 32'h0, 0);
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
      run(3);
      // Trap beats branch; misaligned branch target is aligned.
      drive(0, 0, 1, 32'h103, 1, 32'h200, 1);
      run(1);
      drive(0, 0, 1, 32'h103, 0, 32'h0, 1);
      run(1);
      // Branch pended across a stall.
      drive(0, 1, 1, 32'h80, 0, 32'h0, 1);
      drive(0, 1, 0, 32'h0, 0, 32'h0, 1);
      run(3);
      // Pending trap abandoned by reset mid-wait.
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
      drive(0, 0, 0, 32'h0, 1, 32'h300, 0);
      drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
      run(4);

      for (int i = 0; i < 3000; i++) begin
         bt = ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFF_FF00 | $urandom_range(0, 255));
         tv = $urandom;
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0, bt, $urandom_range(0, 11) == 0, tv,
               $urandom_range(0, 2) != 0);
      end

      @(negedge clk);
      #5;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
